// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory side of the pipeline: store size
// codes and the layout of one buffered store.
package mips_mem_pkg;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_BYTE = 2'b11;

    // Word address field is sized for the widest supported byte address (32 bits).
    localparam int SB_WAW = 30;

    typedef struct packed {
        logic [SB_WAW-1:0] waddr;
        logic [3:0]        be;
        logic [31:0]       data;
    } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Turns a store size code and the low address bits into byte enables and
// lane-replicated data; flags stores that straddle their natural alignment.
module store_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  memwrite,
    input  logic [1:0]  addr,
    input  logic [31:0] writedata,
    output logic [3:0]  be,
    output logic [31:0] data,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b0000;
        data       = writedata;
        misaligned = 1'b0;
        case (memwrite)
            MW_WORD: begin
                be         = 4'b1111;
                misaligned = (addr != 2'b00);
            end
            MW_HALF: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                data       = {2{writedata[15:0]}};
                misaligned = addr[0];
            end
            MW_BYTE: begin
                be   = 4'b0001 << addr;
                data = {4{writedata[7:0]}};
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO of pending stores between the MEM stage and a single-port data memory.
// Drains one store per cycle whenever no hazard-free load owns the port.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    memwrite,
    input  logic          memread,
    input  logic [AW-1:0] dataadr,
    input  logic [31:0]   writedata,
    output logic          st_stall,
    output logic          ld_stall,
    output logic          misalign,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t        entries [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;

    logic [3:0]       al_be;
    logic [31:0]      al_data;
    logic             al_mis;
    logic [SB_WAW-1:0] word_in;
    logic [DEPTH-1:0] valid;
    logic             hit;
    logic             full;
    logic             drain;
    logic             accept;
    sb_entry_t        head_e;

    store_align u_align (
        .memwrite   (memwrite),
        .addr       (dataadr[1:0]),
        .writedata  (writedata),
        .be         (al_be),
        .data       (al_data),
        .misaligned (al_mis)
    );

    assign word_in = SB_WAW'(dataadr[AW-1:2]);

    // Slot i holds a live store when its distance from head is below count.
    always_comb begin
        valid = '0;
        hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = ({1'b0, PW'(i) - head} < count);
            hit      = hit | (valid[i] && (entries[i].waddr == word_in));
        end
    end

    // Stall semantics: st_stall/ld_stall high means the MEM stage must hold its
    // instruction and re-present the same memwrite/memread/dataadr/writedata
    // next cycle; a store is taken exactly in a cycle where accept is high.
    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign ld_stall = memread && hit;
    // A hazarding load yields the port so the blocking entry can drain.
    assign drain    = !empty && (!memread || ld_stall);
    assign st_stall = (memwrite != MW_NONE) && full && !drain;
    assign misalign = (memwrite != MW_NONE) && al_mis && !st_stall;
    assign accept   = (memwrite != MW_NONE) && !al_mis && !st_stall;

    assign head_e    = entries[head];
    assign mem_we    = drain ? head_e.be : 4'b0000;
    assign mem_addr  = {head_e.waddr[AW-3:0], 2'b00};
    assign mem_wdata = head_e.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                entries[tail] <= '{waddr: word_in, be: al_be, data: al_data};
                tail          <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            case ({accept, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic scored against a queue-based model of the store buffer.
module tb_store_buffer;
    import mips_mem_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    memwrite;
    logic          memread;
    logic [AW-1:0] dataadr;
    logic [31:0]   writedata;
    logic          st_stall;
    logic          ld_stall;
    logic          misalign;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry: {word address[29:0], byte enables[3:0], data[31:0]}
    logic [65:0] exp_q[$];

    logic        obs_st, obs_ld, obs_mis, obs_empty;
    logic [3:0]  obs_we;
    logic [31:0] obs_addr, obs_wdata;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .memread   (memread),
        .dataadr   (dataadr),
        .writedata (writedata),
        .st_stall  (st_stall),
        .ld_stall  (ld_stall),
        .misalign  (misalign),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic encode(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] wd,
                          output logic ok, output logic [3:0] be, output logic [31:0] d);
        int lane;
        lane = int'(a % 4);
        ok = 1'b0; be = 4'h0; d = 32'h0;
        case (mw)
            MW_WORD: begin ok = (lane == 0);     be = 4'hF;                    d = wd; end
            MW_HALF: begin ok = (lane % 2 == 0); be = (lane >= 2) ? 4'hC : 4'h3; d = (wd & 32'hFFFF) * 32'h0001_0001; end
            MW_BYTE: begin ok = 1'b1;            be = 4'(1 << lane);           d = (wd & 32'hFF) * 32'h0101_0101; end
            default: ok = 1'b0;
        endcase
    endtask

    // One clock cycle: drive inputs, score outputs against the model, advance model.
    task automatic step(input logic [1:0] mw, input logic rd, input logic [31:0] a, input logic [31:0] wd);
        logic ok, hit, e_ld, e_drain, e_st, e_mis, e_acc;
        logic [3:0]  be;
        logic [31:0] d;
        memwrite = mw; memread = rd; dataadr = a; writedata = wd;
        #1;
        encode(mw, a, wd, ok, be, d);
        hit = 1'b0;
        foreach (exp_q[i]) if (exp_q[i][65:36] == a[31:2]) hit = 1'b1;
        e_ld    = rd && hit;
        e_drain = (exp_q.size() != 0) && (!rd || e_ld);
        e_st    = (mw != MW_NONE) && (exp_q.size() == DEPTH) && !e_drain;
        e_mis   = (mw != MW_NONE) && !ok && !e_st;
        e_acc   = (mw != MW_NONE) && ok && !e_st;
        obs_st = st_stall; obs_ld = ld_stall; obs_mis = misalign; obs_empty = empty;
        obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
        check("st_stall", st_stall, e_st);
        check("ld_stall", ld_stall, e_ld);
        check("misalign", misalign, e_mis);
        check("empty", empty, exp_q.size() == 0);
        check("mem_we", mem_we, e_drain ? exp_q[0][35:32] : 4'h0);
        if (e_drain) begin
            check("mem_addr", mem_addr, {exp_q[0][65:36], 2'b00});
            check("mem_wdata", mem_wdata, exp_q[0][31:0]);
        end
        @(posedge clk);
        if (e_drain) void'(exp_q.pop_front());
        if (e_acc) exp_q.push_back({a[31:2], be, d});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(MW_NONE, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        memwrite = MW_NONE; memread = 1'b0; dataadr = '0; writedata = '0;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_empty", empty, 1'b1);
        check("rst_mem_we", mem_we, 4'h0);
        check("rst_st_stall", st_stall, 1'b0);
        check("rst_ld_stall", ld_stall, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        memwrite = MW_NONE; memread = 1'b0; dataadr = '0; writedata = '0;
        do_reset();

        // Basic word store
        step(MW_WORD, 1'b0, 32'd84, 32'd7);
        idle(1);
        check("sw_we", obs_we, 4'hF);
        check("sw_addr", obs_addr, 32'd84);
        check("sw_data", obs_wdata, 32'd7);
        idle(1);
        check("sw_empty_after", obs_empty, 1'b1);

        // Byte and half lanes
        step(MW_BYTE, 1'b0, 32'h55, 32'hAB);
        idle(1);
        check("sb_we", obs_we, 4'b0010);
        check("sb_data", obs_wdata, 32'hABABABAB);
        check("sb_addr", obs_addr, 32'h54);
        step(MW_HALF, 1'b0, 32'h56, 32'h1234);
        idle(1);
        check("sh_we", obs_we, 4'b1100);
        check("sh_data", obs_wdata, 32'h12341234);

        // Fill under a hazard-free load, then full+drain accepts
        for (int i = 0; i < 4; i++) step(MW_WORD, 1'b1, 32'(i * 4), 32'(100 + i));
        step(MW_WORD, 1'b1, 32'd16, 32'd104);
        check("full_st_stall", obs_st, 1'b1);
        step(MW_WORD, 1'b0, 32'd16, 32'd104);
        check("full_drain_accept", obs_st, 1'b0);
        check("drain0_addr", obs_addr, 32'd0);
        for (int i = 1; i < 5; i++) begin
            idle(1);
            check("drain_order_addr", obs_addr, 32'(i * 4));
        end
        idle(1);

        // Load hazard on a queued word
        step(MW_WORD, 1'b0, 32'h50, 32'd5);
        step(MW_NONE, 1'b1, 32'h52, 32'd0);
        check("haz_ld_stall", obs_ld, 1'b1);
        check("haz_we", obs_we, 4'hF);
        check("haz_addr", obs_addr, 32'h50);
        step(MW_NONE, 1'b1, 32'h52, 32'd0);
        check("haz_clear", obs_ld, 1'b0);

        // Misaligned word store
        step(MW_WORD, 1'b0, 32'h52, 32'd9);
        check("mis_pulse", obs_mis, 1'b1);
        check("mis_no_stall", obs_st, 1'b0);
        idle(1);
        check("mis_no_write", obs_we, 4'h0);
        check("mis_gone", obs_mis, 1'b0);

        // Reset mid-drain
        step(MW_WORD, 1'b1, 32'h200, 32'd1);
        step(MW_WORD, 1'b1, 32'h204, 32'd2);
        step(MW_WORD, 1'b1, 32'h208, 32'd3);
        idle(1);
        check("pre_rst_drain", obs_addr, 32'h200);
        do_reset();
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)),
                     $urandom);
            end
        end
        idle(DEPTH + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the pipeline MEM stage (top-level `dataadr`, `writedata`, 2-bit `memwrite`) and the single-port data memory.
- Queues stores in a small FIFO and drains one store per cycle whenever the memory port is not taken by a load.
- Stalls a load that hits a queued word until that word has drained, so loads never read stale data.
- Converts the `memwrite` size code into byte enables and lane-replicated write data.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, >=2)
- AW, 32, address width

Ports:
- clk        in   1   clock, all state updates on rising edge
- reset      in   1   synchronous, active-high; clears the buffer
- memwrite   in   2   store size code from MEM stage: 00 none, 01 word, 10 half, 11 byte
- memread    in   1   load in MEM stage this cycle
- dataadr    in   AW  byte address of load/store
- writedata  in   32  store data, right-justified
- st_stall   out  1   store not accepted this cycle; MEM stage holds
- ld_stall   out  1   load hits a queued word; MEM stage holds
- misalign   out  1   one-cycle pulse: store dropped, misaligned
- mem_we     out  4   byte enables to data memory, 0 = no write
- mem_addr   out  AW  word-aligned write address (bits [1:0] = 0)
- mem_wdata  out  32  lane-replicated write data
- empty      out  1   no entries queued

Behaviour:
- Reset (synchronous) clears count, head and tail, and discards all entries. Outputs after reset: empty=1, mem_we=0, st_stall=0, ld_stall=0, misalign=0. Reset overrides any simultaneous accept or drain.
- Entry contents: word address (dataadr[AW-1:2]), 4-bit byte enable, 32-bit lane data.
- Encoding of each store size:
  - word: be=1111, data unchanged; requires addr[1:0]=00.
  - half: be = addr[1] ? 1100 : 0011, data = {2{wd[15:0]}}; requires addr[0]=0.
  - byte: be = 0001 << addr[1:0], data = {4{wd[7:0]}}.
- Misaligned store: not enqueued. misalign=1 for that cycle only, st_stall=0, and the pipeline proceeds.
- ld_stall (combinational) = memread && some valid entry's word address == dataadr[AW-1:2]. Any byte overlap within the word counts as a hit.
- drain (combinational) = !empty && (!memread || ld_stall).
  - A load without a hazard owns the memory port.
  - A load with a hazard yields the port, so draining proceeds and the stall cannot deadlock.
- st_stall (combinational) = memwrite!=00 && count==DEPTH && !drain.
- accept = memwrite!=00 && aligned && !st_stall.
- Memory port (combinational from the head entry):
  - When drain: mem_we = head be, mem_addr = {head word addr, 2'b00}, mem_wdata = head data.
  - Otherwise mem_we=0; mem_addr and mem_wdata are don't-care (held at head values).
- Latency: a store accepted at edge N is presented on the memory port during the cycle after N, at the earliest. Memory commits it at the following edge.
- Simultaneous accept and drain: count is unchanged and head/tail both advance. When full, this is exactly the case in which a store is accepted.
- Ordering: strict FIFO. Stores to the same word drain in program order. There is no merging.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. empty = (count==0).
- ld_stall and st_stall may both be high in one cycle. The MEM stage holds either way.

Decomposition:
- Shared package mips_mem_pkg:
  - memwrite encodings MW_NONE, MW_WORD, MW_HALF, MW_BYTE
  - typedef sb_entry_t {word addr, be, data}
- Sub-module store_align: combinational. Takes memwrite, addr[1:0] and writedata; produces be, lane data and misaligned. It is reused by the future load-extract path.
- The FIFO storage, pointers, and hazard compare live in store_buffer.

Test Plan:
- Basic store: sw, dataadr=84, writedata=7, memread=0 → next cycle mem_we=1111, mem_addr=84, mem_wdata=7; empty=1 the cycle after.
- Byte lanes:
  - sb to 0x55, data 0xAB → mem_we=0010, mem_wdata=0xABABABAB, mem_addr=0x54.
  - sh to 0x56, data 0x1234 → mem_we=1100, mem_wdata=0x12341234.
- Full/backpressure:
  - Hold memread=1 to non-hitting address 0x100 while issuing 5 sw to 0,4,8,12,16 → fifth sees st_stall=1.
  - Drop memread → drains in order 0,4,8,12, then 16 is accepted; full+drain in the same cycle accepts.
- Load hazard:
  - sw 0x50=5, then next cycle lw 0x52 → ld_stall=1 while the entry drains (mem_we=1111, mem_addr=0x50).
  - ld_stall=0 the following cycle.
- Misaligned and reset:
  - sw to 0x52 → misalign=1 one cycle, no mem_we ever.
  - Queue 3 stores, assert reset mid-drain → next cycle empty=1, mem_we=0, and no further writes.
